conv_perf_counter: RTL and testbench

Synthesizable performance counter for the conv2D accelerator. It sits beside the HLS core and taps the same control signals: the block-level ap_start/ap_ready/ap_done/ap_continue handshake and the pipelined-loop iteration/stall strobes. It accumulates invocation, latency, interval, iteration and stall statistics in saturating counters, which a simple synchronous read port exposes to the AXI-lite register wrapper, so on-board runs yield the same figures the simulation dataflow dumps produce.

---
 rtl/conv_perf_counter.sv | 223 ++++++++++++++++++++++
 tb/tb_conv_perf_counter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_perf_counter.sv
// conv_perf_counter: performance statistics for the conv2D HLS core.
// Watches the ap_start/ap_done/ap_continue handshake plus loop iteration and
// stall strobes, accumulates saturating statistics and exposes them through
// a one-cycle-latency synchronous read port.
// Optional feature: define PERF_STALL_CNT_EN to build the stall cycle counter;
// without it the stall input is ignored and address 6 reads zero.
module conv_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             iter_end,
   input  logic             stall,
   input  logic             clr,
   input  logic             rd_en,
   input  logic [3:0]       rd_addr,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   state_t state_reg;
   state_t state_next;

   logic [CNT_W-1:0] lat_cnt;
   logic [CNT_W-1:0] lat_now;
   logic [CNT_W-1:0] invocations;
   logic [CNT_W-1:0] last_lat;
   logic [CNT_W-1:0] min_lat;
   logic [CNT_W-1:0] max_lat;
   logic [CNT_W-1:0] busy_cycles;
   logic [CNT_W-1:0] iterations;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] last_interval;
   logic [CNT_W-1:0] int_cnt;
   logic             have_prev;

   logic start_evt;
   logic done_evt;
   logic busy_inc;
   logic iter_inc;
   logic int_inc;
   logic lat_sat;
   logic inv_sat;
   logic busy_sat;
   logic iter_sat;
   logic int_sat;
   logic stall_sat;
   logic any_sat;

   // ap_ready carries no information beyond ap_start/ap_done for statistics.
   logic ready_unused;
   assign ready_unused = ap_ready;

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state_reg <= IDLE;
      else           state_reg <= state_next;
   end

   // Next-state logic; a start coincident with done in IDLE is a 1-cycle run.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (ap_start && !ap_done) state_next = RUN;
         RUN:     if (ap_done) state_next = ap_continue ? IDLE : WAIT;
         WAIT:    if (ap_continue) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign start_evt = (state_reg == IDLE) && ap_start;
   assign done_evt  = ((state_reg == RUN) && ap_done) || (start_evt && ap_done);
   assign busy_inc  = (state_reg != IDLE) || start_evt;
   assign iter_inc  = iter_end && (state_reg != IDLE);
   assign int_inc   = have_prev && !start_evt;

   // Latency of the current cycle, counting the start cycle as 1.
   assign lat_now   = (state_reg == RUN) ? sat_inc(lat_cnt) : ONE;

   assign lat_sat   = (state_reg == RUN) && (&lat_cnt);
   assign inv_sat   = done_evt && (&invocations);
   assign busy_sat  = busy_inc && (&busy_cycles);
   assign iter_sat  = iter_inc && (&iterations);
   assign int_sat   = int_inc && (&int_cnt);
   assign any_sat   = lat_sat | inv_sat | busy_sat | iter_sat | int_sat | stall_sat;

   assign busy = (state_reg != IDLE);

   // Per-invocation latency timer; left running across clr so an in-flight
   // invocation still reports its true latency.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)                              lat_cnt <= '0;
      else if (start_evt || (state_reg == RUN))  lat_cnt <= lat_now;
   end

   // Invocation and latency statistics, captured on completion.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         invocations <= '0;
         last_lat    <= '0;
         min_lat     <= '1;
         max_lat     <= '0;
      end else if (clr) begin
         invocations <= '0;
         last_lat    <= '0;
         min_lat     <= '1;
         max_lat     <= '0;
      end else if (done_evt) begin
         invocations <= sat_inc(invocations);
         last_lat    <= lat_now;
         if (lat_now < min_lat) min_lat <= lat_now;
         if (lat_now > max_lat) max_lat <= lat_now;
      end
   end

   // Busy and iteration accumulators.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         busy_cycles <= '0;
         iterations  <= '0;
      end else if (clr) begin
         busy_cycles <= '0;
         iterations  <= '0;
      end else begin
         if (busy_inc) busy_cycles <= sat_inc(busy_cycles);
         if (iter_inc) iterations  <= sat_inc(iterations);
      end
   end

   // Start-to-start interval timer; idle until the first start after reset/clr.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         have_prev     <= 1'b0;
         int_cnt       <= '0;
         last_interval <= '0;
      end else if (clr) begin
         have_prev     <= 1'b0;
         int_cnt       <= '0;
         last_interval <= '0;
      end else if (start_evt) begin
         if (have_prev) last_interval <= int_cnt;
         have_prev <= 1'b1;
         int_cnt   <= ONE;
      end else if (int_inc) begin
         int_cnt <= sat_inc(int_cnt);
      end
   end

`ifdef PERF_STALL_CNT_EN
   logic stall_inc;
   assign stall_inc = stall && (state_reg == RUN);
   assign stall_sat = stall_inc && (&stall_cycles);

   // Stall cycles while the pipeline is running.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)      stall_cycles <= '0;
      else if (clr)       stall_cycles <= '0;
      else if (stall_inc) stall_cycles <= sat_inc(stall_cycles);
   end
`else
   logic stall_unused;
   assign stall_unused = stall;
   assign stall_cycles = '0;
   assign stall_sat    = 1'b0;
`endif

   // Sticky overflow flag.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)    ovf <= 1'b0;
      else if (clr)     ovf <= 1'b0;
      else if (any_sat) ovf <= 1'b1;
   end

   // Register map.
   logic [CNT_W-1:0] reg_map [0:15];
   assign reg_map[0] = invocations;
   assign reg_map[1] = last_lat;
   assign reg_map[2] = min_lat;
   assign reg_map[3] = max_lat;
   assign reg_map[4] = busy_cycles;
   assign reg_map[5] = iterations;
   assign reg_map[6] = stall_cycles;
   assign reg_map[7] = last_interval;
   assign reg_map[8] = {{(CNT_W-3){1'b0}}, ovf, state_reg};

   genvar gi;
   generate
      for (gi = 9; gi < 16; gi++) begin : g_unmapped
         assign reg_map[gi] = '0;
      end
   endgenerate

   // Registered read port: returns the state as of the end of the previous cycle.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= reg_map[rd_addr];
      end
   end

endmodule

// File: tb/tb_conv_perf_counter.sv
// Testbench for conv_perf_counter: a 32-bit and an 8-bit instance share the
// core handshake; reads are checked by a scoreboard against a transaction-
// level model of the statistics.
module tb_conv_perf_counter;

   logic ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   logic ap_rst_n, ap_start, ap_ready, ap_done, ap_continue;
   logic iter_end, stall, clr, rd_en, rd_en8;
   logic [3:0] rd_addr;
   logic [31:0] rd_data;
   logic [7:0] rd_data8;
   logic rd_valid, busy, ovf, rd_valid8, busy8, ovf8;

   conv_perf_counter #(.CNT_W(32)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .iter_end(iter_end), .stall(stall),
      .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .ovf(ovf));

   conv_perf_counter #(.CNT_W(8)) dut8 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .iter_end(iter_end), .stall(stall),
      .clr(clr), .rd_en(rd_en8), .rd_addr(rd_addr), .rd_data(rd_data8),
      .rd_valid(rd_valid8), .busy(busy8), .ovf(ovf8));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [7:0]  exp8_q[$];
   string       name8_q[$];
   logic        exp_valid  = 1'b0;
   logic        exp_valid8 = 1'b0;

   // Reference model of the 32-bit instance's statistics.
   longint m_inv, m_last, m_min, m_max, m_busy, m_iter, m_stall, m_int, m_prev;
   bit     m_have_prev;
   localparam longint MAX32 = 64'hFFFF_FFFF;

   function automatic longint sat32(longint x);
      return (x > MAX32) ? MAX32 : x;
   endfunction

   task automatic model_clr();
      m_inv = 0; m_last = 0; m_min = MAX32; m_max = 0; m_busy = 0;
      m_iter = 0; m_stall = 0; m_int = 0; m_prev = 0; m_have_prev = 0;
   endtask

   function automatic longint mval(int a);
      case (a)
         0: return m_inv;
         1: return m_last;
         2: return m_min;
         3: return m_max;
         4: return m_busy;
         5: return m_iter;
`ifdef PERF_STALL_CNT_EN
         6: return m_stall;
`else
         6: return 0;
`endif
         7: return m_int;
         8: return 0;       // ovf never set and FSM idle when model is read
         default: return 0;
      endcase
   endfunction

   task automatic chk(string nm, longint act, longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
      cyc++;
   endtask

   // Expected rd_valid follows each sampled rd_en by one cycle.
   always @(posedge ap_clk) begin
      exp_valid  <= rd_en;
      exp_valid8 <= rd_en8;
   end

   // Monitor: compare read responses against the scoreboard.
   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         if (exp_valid || rd_valid) chk("rd_valid", longint'(rd_valid), longint'(exp_valid));
         if (exp_valid8 || rd_valid8) chk("rd_valid8", longint'(rd_valid8), longint'(exp_valid8));
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_unexpected: got 0x%0h with no request outstanding", rd_data);
            end else begin
               automatic logic [31:0] e = exp_q.pop_front();
               automatic string n = name_q.pop_front();
               chk(n, longint'(rd_data), longint'(e));
            end
         end
         if (rd_valid8) begin
            if (exp8_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rd8_unexpected: got 0x%0h with no request outstanding", rd_data8);
            end else begin
               automatic logic [7:0] e8 = exp8_q.pop_front();
               automatic string n8 = name8_q.pop_front();
               chk(n8, longint'(rd_data8), longint'(e8));
            end
         end
      end
   end

   task automatic rd(int a, longint expv);
      rd_en = 1'b1; rd_addr = 4'(a);
      exp_q.push_back(32'(expv));
      name_q.push_back($sformatf("reg%0d", a));
      tick();
      rd_en = 1'b0;
   endtask

   task automatic rd8(int a, longint expv);
      rd_en8 = 1'b1; rd_addr = 4'(a);
      exp8_q.push_back(8'(expv));
      name8_q.push_back($sformatf("reg8_%0d", a));
      tick();
      rd_en8 = 1'b0;
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) rd(a, mval(a));
   endtask

   task automatic do_clr();
      clr = 1'b1; tick(); clr = 1'b0;
      model_clr();
   endtask

   // Idle cycles, optionally with iteration/stall noise that must be ignored.
   task automatic idle(int n, bit noise);
      for (int i = 0; i < n; i++) begin
         iter_end = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         stall    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      iter_end = 1'b0; stall = 1'b0;
   endtask

   // One invocation of latency lat, held wt cycles in WAIT, with iters
   // iteration pulses and stalls stall cycles inside the run.
   task automatic run_inv(int lat, int wt, int iters, int stalls);
      if (m_have_prev) m_int = sat32(cyc - m_prev);
      m_prev = cyc; m_have_prev = 1;
      ap_start = 1'b1; ap_done = (lat == 1); ap_continue = 1'b1;
      tick();
      if (lat > 1) chk("busy_rise", longint'(busy), 1);
      ap_done = 1'b0;
      for (int c = 2; c <= lat; c++) begin
         ap_start = (c == 2);
         ap_ready = (c == 2);
         iter_end = ((c - 2) < iters);
         stall    = ((c - 2) >= (lat - 1 - stalls));
         if (c == lat) begin
            ap_done = 1'b1; ap_continue = (wt == 0);
         end
         tick();
      end
      ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; iter_end = 1'b0; stall = 1'b0;
      for (int w = 1; w <= wt; w++) begin
         ap_continue = (w == wt);
         rd_en = (w == 1); rd_addr = 4'd8;
         if (w == 1) begin
            exp_q.push_back(32'd2);
            name_q.push_back("status_wait");
         end
         tick();
         rd_en = 1'b0;
         chk("busy_wait", longint'(busy), longint'(w < wt));
      end
      ap_continue = 1'b1;
      chk("busy_end", longint'(busy), 0);
      m_inv  = sat32(m_inv + 1);
      m_last = lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      m_busy  = sat32(m_busy + lat + wt);
      m_iter  = sat32(m_iter + iters);
      m_stall = sat32(m_stall + stalls);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      ap_rst_n = 1'b0; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
      ap_continue = 1'b1; iter_end = 1'b0; stall = 1'b0; clr = 1'b0;
      rd_en = 1'b0; rd_en8 = 1'b0; rd_addr = 4'd0;
      model_clr();
      tick(); tick(); tick();
      ap_rst_n = 1'b1;
      tick();

      // Reset state
      chk("reset_rd_valid", longint'(rd_valid), 0);
      chk("reset_rd_data", longint'(rd_data), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_ovf", longint'(ovf), 0);
      read_all();

      // Single invocation of latency 10
      run_inv(10, 0, 0, 0);
      idle(3, 0);
      read_all();

      // Three runs, starts 20 cycles apart
      do_clr();
      run_inv(12, 0, 0, 0); idle(8, 1);
      run_inv(7, 0, 0, 0);  idle(13, 1);
      run_inv(9, 0, 0, 0);  idle(4, 0);
      read_all();

      // Done held off by ap_continue for 4 cycles
      run_inv(6, 4, 2, 1);
      idle(2, 0);
      read_all();

      // Iterations and stalls inside the run, iteration pulses ignored while idle
      do_clr();
      run_inv(20, 0, 16, 5);
      for (int i = 0; i < 3; i++) begin
         iter_end = 1'b1; tick(); iter_end = 1'b0; tick();
      end
      read_all();

      // Randomized invocations
      for (int k = 0; k < 10; k++) begin
         automatic int lat = $urandom_range(1, 40);
         automatic int wt  = (lat > 1) ? $urandom_range(0, 3) : 0;
         automatic int it  = $urandom_range(0, lat - 1);
         automatic int st  = $urandom_range(0, lat - 1);
         run_inv(lat, wt, it, st);
         idle($urandom_range(0, 10), 1);
         for (int r = 0; r < 3; r++) begin
            automatic int a = $urandom_range(0, 15);
            rd(a, mval(a));
         end
      end
      read_all();

      // 8-bit saturation, then clr coincident with ap_done
      do_clr();
      if (m_have_prev) m_int = sat32(cyc - m_prev);
      m_prev = cyc; m_have_prev = 1;
      ap_start = 1'b1;
      tick();
      for (int c = 2; c <= 300; c++) begin
         ap_start = (c == 2);
         ap_ready = (c == 2);
         rd_en8 = (c == 290) || (c == 291);
         rd_addr = (c == 290) ? 4'd4 : 4'd8;
         if (c == 290) begin exp8_q.push_back(8'd255); name8_q.push_back("busy_sat8"); end
         if (c == 291) begin exp8_q.push_back(8'd5);   name8_q.push_back("status_ovf8"); end
         if (c == 300) begin ap_done = 1'b1; clr = 1'b1; end
         tick();
         rd_en8 = 1'b0;
         if (c == 295) chk("ovf8_set", longint'(ovf8), 1);
      end
      ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; clr = 1'b0;
      model_clr();
      chk("ovf8_cleared", longint'(ovf8), 0);
      chk("busy8_idle", longint'(busy8), 0);
      for (int a = 0; a < 9; a++) rd8(a, (a == 2) ? 255 : 0);
      read_all();

      idle(3, 0);
      chk("queue_drain", longint'(exp_q.size() + exp8_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
